// File: rtl/tiny1_mmio_uart.sv
// tiny1_mmio_uart: memory-mapped UART bridge for the tiny1 SoC.
//
// Sits behind the mem_addr[15] mmap select. Received bytes are buffered in an
// RX FIFO, outgoing bytes in a TX FIFO drained through a valid/ready port.
// Provides sticky overflow flags (W1C), an optional level IRQ and a halt strobe.
//
// Optional feature macro: TINY1_MMIO_IRQ_EN
//   defined     -> IRQ_MASK register and registered irq output are present
//   not defined -> irq tied to 0, irqack ignored, IRQ_MASK reads 0
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_addr        core address ([15] mmap select, [10:0] register offset)
//   mem_data_o      core write data
//   mem_wr, mem_rd  core write / read strobes
//   mmio_data_i     registered read data returned to the core
//   uart_din        received byte, qualified by uart_valid
//   uart_out        TX FIFO head byte, qualified by uart_out_valid
//   uart_out_ready  sink accepts uart_out this cycle
//   irq, irqack     level interrupt request / acknowledge
//   halt            one-cycle pulse after a write to IO_HALT
//
// Register map (byte offsets):
//   0 RX_STATUS  R   [0] rx_nonempty, [15:8] rx_count
//   2 RX_DATA    R   {8'b0, head}, pops; returns 0 when empty
//   4 TX_STATUS  R   [0] tx_not_full, [1] tx_empty, [15:8] tx_count
//   6 TX_DATA    W   push mem_data_o[7:0]
//   8 IRQ_MASK   RW  [0] rx_nonempty enable, [1] tx_empty enable
//  10 ERR        R/W1C [0] rx_overflow, [1] tx_overflow
//   IO_HALT      W   halt pulse

module tiny1_mmio_uart #(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned IO_HALT  = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data_o,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [15:0] mmio_data_i,
  input  logic [7:0]  uart_din,
  input  logic        uart_valid,
  output logic [7:0]  uart_out,
  output logic        uart_out_valid,
  input  logic        uart_out_ready,
  output logic        irq,
  input  logic        irqack,
  output logic        halt
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);

  localparam logic [10:0] OFF_RX_STATUS = 11'd0;
  localparam logic [10:0] OFF_RX_DATA   = 11'd2;
  localparam logic [10:0] OFF_TX_STATUS = 11'd4;
  localparam logic [10:0] OFF_TX_DATA   = 11'd6;
  localparam logic [10:0] OFF_IRQ_MASK  = 11'd8;
  localparam logic [10:0] OFF_ERR       = 11'd10;
  localparam logic [10:0] OFF_HALT      = IO_HALT[10:0];

  // Bus decode
  logic        mm_rd;
  logic        mm_wr;
  logic [10:0] off;

  assign mm_rd = mem_addr[15] & mem_rd;
  assign mm_wr = mem_addr[15] & mem_wr;
  assign off   = mem_addr[10:0];

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
  logic [RX_AW:0] rx_rptr_q, rx_rptr_d;
  logic [RX_AW:0] rx_count;
  logic [7:0]     rx_cnt8;
  logic [7:0]     rx_head;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_pop;
  logic           rx_push;
  logic           rx_ovf_set;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  // Full when the low bits match but the wrap bits differ.
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign rx_cnt8  = 8'(rx_count);
  assign rx_head  = rx_mem_q[rx_rptr_q[RX_AW-1:0]];

  assign rx_pop     = mm_rd && (off == OFF_RX_DATA) && !rx_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_push    = uart_valid && (!rx_full || rx_pop);
  assign rx_ovf_set = uart_valid && rx_full && !rx_pop;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + {{RX_AW{1'b0}}, 1'b1};
    if (rx_pop)  rx_rptr_d = rx_rptr_q + {{RX_AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= uart_din;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW:0] tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0] tx_count;
  logic [7:0]     tx_cnt8;
  logic [7:0]     tx_head;
  logic           tx_empty;
  logic           tx_full;
  logic           tx_wr;
  logic           tx_hs;
  logic           tx_push;
  logic           tx_ovf_set;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign tx_count = tx_wptr_q - tx_rptr_q;
  assign tx_cnt8  = 8'(tx_count);
  assign tx_head  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];

  // Valid is masked during reset so no byte can be handed off while the
  // FIFO is being discarded.
  assign uart_out_valid = !tx_empty && !rst;
  assign uart_out       = uart_out_valid ? tx_head : '0;

  assign tx_wr      = mm_wr && (off == OFF_TX_DATA);
  assign tx_hs      = uart_out_valid && uart_out_ready;
  assign tx_push    = tx_wr && (!tx_full || tx_hs);
  assign tx_ovf_set = tx_wr && tx_full && !tx_hs;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + {{TX_AW{1'b0}}, 1'b1};
    if (tx_hs)   tx_rptr_d = tx_rptr_q + {{TX_AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= mem_data_o[7:0];
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: set wins over a simultaneous W1C clear
  // ---------------------------------------------------------------------------
  logic [1:0] err_q, err_d;
  logic [1:0] err_clr;

  assign err_clr = (mm_wr && (off == OFF_ERR)) ? mem_data_o[1:0] : 2'b00;

  always_comb begin
    err_d = (err_q & ~err_clr) | {tx_ovf_set, rx_ovf_set};
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
  logic [15:0] mask_rd;

`ifdef TINY1_MMIO_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;
  logic       irq_cond;

  assign irq_cond = (mask_q[0] && !rx_empty) || (mask_q[1] && tx_empty);

  always_comb begin
    mask_d = mask_q;
    if (mm_wr && (off == OFF_IRQ_MASK)) mask_d = mem_data_o[1:0];
    irq_d = irq_cond && !irqack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign mask_rd = {14'b0, mask_q};

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_addr[14:11], mem_data_o[15:8]};
`else
  assign irq     = 1'b0;
  assign mask_rd = '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_addr[14:11], mem_data_o[15:8], irqack};
`endif

  // ---------------------------------------------------------------------------
  // Read data register: holds the last mmap read result
  // ---------------------------------------------------------------------------
  logic [15:0] rdata_d;
  logic [15:0] mmio_q;

  always_comb begin
    rdata_d = '0;
    case (off)
      OFF_RX_STATUS: rdata_d = {rx_cnt8, 7'b0, !rx_empty};
      OFF_RX_DATA:   rdata_d = rx_empty ? 16'h0000 : {8'b0, rx_head};
      OFF_TX_STATUS: rdata_d = {tx_cnt8, 6'b0, tx_empty, !tx_full};
      OFF_IRQ_MASK:  rdata_d = mask_rd;
      OFF_ERR:       rdata_d = {14'b0, err_q};
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        mmio_q <= '0;
    else if (mm_rd) mmio_q <= rdata_d;
  end

  assign mmio_data_i = mmio_q;

  // ---------------------------------------------------------------------------
  // Halt strobe
  // ---------------------------------------------------------------------------
  logic halt_q;

  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= mm_wr && (off == OFF_HALT);
  end

  assign halt = halt_q;

endmodule

// File: tb/tb_tiny1_mmio_uart.sv
// Scoreboard bench for tiny1_mmio_uart. Stimulus pushes expected read data and
// expected TX bytes into queues; a negedge monitor pops and compares whenever
// a read result or a TX handshake is presented.

module tb_tiny1_mmio_uart;

  localparam int unsigned RXD = 16;
  localparam int unsigned TXD = 16;

  localparam logic [10:0] A_RXS  = 11'd0;
  localparam logic [10:0] A_RXD  = 11'd2;
  localparam logic [10:0] A_TXS  = 11'd4;
  localparam logic [10:0] A_TXD  = 11'd6;
  localparam logic [10:0] A_MASK = 11'd8;
  localparam logic [10:0] A_ERR  = 11'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_o;
  logic        mem_wr;
  logic        mem_rd;
  logic [15:0] mmio_data_i;
  logic [7:0]  uart_din;
  logic        uart_valid;
  logic [7:0]  uart_out;
  logic        uart_out_valid;
  logic        uart_out_ready;
  logic        irq;
  logic        irqack;
  logic        halt;

  always #5 clk = ~clk;

  tiny1_mmio_uart #(
    .RX_DEPTH(RXD),
    .TX_DEPTH(TXD),
    .IO_HALT (512)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_data_o    (mem_data_o),
    .mem_wr        (mem_wr),
    .mem_rd        (mem_rd),
    .mmio_data_i   (mmio_data_i),
    .uart_din      (uart_din),
    .uart_valid    (uart_valid),
    .uart_out      (uart_out),
    .uart_out_valid(uart_out_valid),
    .uart_out_ready(uart_out_ready),
    .irq           (irq),
    .irqack        (irqack),
    .halt          (halt)
  );

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t tx_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor
  logic rd_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%04h expected no read result", mmio_data_i);
      end else begin
        e = rd_q.pop_front();
        check(e.name, mmio_data_i, e.val);
      end
    end
    rd_seen = mem_rd && mem_addr[15] && !rst;
    if (uart_out_valid && uart_out_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected no handshake", uart_out);
      end else begin
        e = tx_q.pop_front();
        check(e.name, {8'h00, uart_out}, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [10:0] off, input logic [15:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    mem_addr = {5'b10000, off};
    mem_rd   = 1'b1;
    tick();
    mem_rd   = 1'b0;
  endtask

  task automatic wr(input logic [10:0] off, input logic [15:0] data);
    mem_addr   = {5'b10000, off};
    mem_data_o = data;
    mem_wr     = 1'b1;
    tick();
    mem_wr     = 1'b0;
  endtask

  task automatic tx_wr(input logic [7:0] b, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.name = "tx_byte";
      e.val  = {8'h00, b};
      tx_q.push_back(e);
    end
    wr(A_TXD, {8'h00, b});
  endtask

  task automatic rx_in(input logic [7:0] b);
    uart_din   = b;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_addr = '0;
    mem_data_o = '0;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    uart_din = '0;
    uart_valid = 1'b0;
    uart_out_ready = 1'b0;
    irqack = 1'b0;

    // Reset state
    tick();
    check("rst_valid", {15'b0, uart_out_valid}, 16'h0000);
    check("rst_out", {8'h00, uart_out}, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    check("rst_halt", {15'b0, halt}, 16'h0000);
    check("rst_mmio", mmio_data_i, 16'h0000);
    tick();
    rst = 1'b0;

    rd(A_RXS, 16'h0000, "rx_status_reset");
    rd(A_TXS, 16'h0003, "tx_status_reset");
    rd(A_ERR, 16'h0000, "err_reset");
    check("valid_idle", {15'b0, uart_out_valid}, 16'h0000);

    // Basic RX
    rx_in(8'h41);
    rx_in(8'h42);
    rd(A_RXS, 16'h0201, "rx_status_2");
    rd(A_RXD, 16'h0041, "rx_data_41");
    rd(A_RXD, 16'h0042, "rx_data_42");
    rd(A_RXS, 16'h0000, "rx_status_empty");
    rd(A_RXD, 16'h0000, "rx_data_empty");

    // Empty FIFO: read and push in the same cycle
    uart_din = 8'h77;
    uart_valid = 1'b1;
    rd(A_RXD, 16'h0000, "rx_empty_rd_push");
    uart_valid = 1'b0;
    rd(A_RXS, 16'h0101, "rx_status_1");
    mem_addr = 16'h0002;
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    check("mmio_hold", mmio_data_i, 16'h0101);
    rd(A_RXD, 16'h0077, "rx_data_77");

    // RX overflow, then full + simultaneous pop
    for (int i = 0; i < 17; i++) rx_in(8'h80 + 8'(i));
    rd(A_RXS, 16'h1001, "rx_status_full");
    rd(A_ERR, 16'h0001, "err_rx_ovf");
    wr(A_ERR, 16'h0001);
    rd(A_ERR, 16'h0000, "err_rx_clr");
    uart_din = 8'hAA;
    uart_valid = 1'b1;
    rd(A_RXD, 16'h0080, "rx_full_pop");
    uart_valid = 1'b0;
    rd(A_RXS, 16'h1001, "rx_status_full_pp");
    rd(A_ERR, 16'h0000, "err_no_ovf_pp");
    for (int i = 1; i < 16; i++) rd(A_RXD, 16'h0080 + 16'(i), "rx_drain");
    rd(A_RXD, 16'h00AA, "rx_drain_aa");
    rd(A_RXS, 16'h0000, "rx_status_drained");

    // TX basic with back-pressure
    tx_wr(8'h55, 1'b1);
    check("tx_valid_first", {15'b0, uart_out_valid}, 16'h0001);
    check("tx_out_first", {8'h00, uart_out}, 16'h0055);
    tx_wr(8'h66, 1'b1);
    tick();
    check("tx_out_stable", {8'h00, uart_out}, 16'h0055);
    rd(A_TXS, 16'h0201, "tx_status_2");
    uart_out_ready = 1'b1;
    tick();
    tick();
    uart_out_ready = 1'b0;
    check("tx_valid_drained", {15'b0, uart_out_valid}, 16'h0000);
    rd(A_TXS, 16'h0003, "tx_status_empty");

    // Non-mmap write to TX_DATA offset is not a push
    mem_addr = 16'h0006;
    mem_data_o = 16'h0033;
    mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
    tick();
    check("tx_nommap", {15'b0, uart_out_valid}, 16'h0000);

    // TX overflow, then full + simultaneous handshake
    for (int i = 0; i < 17; i++) tx_wr(8'hC0 + 8'(i), i < 16);
    rd(A_TXS, 16'h1000, "tx_status_full");
    rd(A_ERR, 16'h0002, "err_tx_ovf");
    uart_out_ready = 1'b1;
    tx_wr(8'hEE, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    uart_out_ready = 1'b0;
    check("tx_valid_after_full", {15'b0, uart_out_valid}, 16'h0000);
    rd(A_ERR, 16'h0002, "err_tx_sticky");
    wr(A_ERR, 16'h0002);
    rd(A_ERR, 16'h0000, "err_tx_clr");

    // Overflow set and W1C clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) rx_in(8'h20 + 8'(i));
    uart_din = 8'h99;
    uart_valid = 1'b1;
    wr(A_ERR, 16'h0001);
    uart_valid = 1'b0;
    rd(A_ERR, 16'h0001, "err_set_wins");

    // Reset mid-transfer discards everything
    tx_wr(8'h11, 1'b0);
    tx_wr(8'h22, 1'b0);
    check("tx_valid_pre_rst", {15'b0, uart_out_valid}, 16'h0001);
    uart_out_ready = 1'b1;
    rst = 1'b1;
    #0;
    check("tx_valid_in_rst", {15'b0, uart_out_valid}, 16'h0000);
    tick();
    rst = 1'b0;
    uart_out_ready = 1'b0;
    rd(A_RXS, 16'h0000, "rx_status_post_rst");
    rd(A_TXS, 16'h0003, "tx_status_post_rst");
    rd(A_ERR, 16'h0000, "err_post_rst");

    // Interrupt
`ifdef TINY1_MMIO_IRQ_EN
    wr(A_MASK, 16'h0001);
    rd(A_MASK, 16'h0001, "mask_rd");
    rx_in(8'h10);
    tick();
    check("irq_set", {15'b0, irq}, 16'h0001);
    irqack = 1'b1;
    tick();
    irqack = 1'b0;
    check("irq_ack_low", {15'b0, irq}, 16'h0000);
    tick();
    check("irq_reassert", {15'b0, irq}, 16'h0001);
    rd(A_RXD, 16'h0010, "irq_rx_data");
    tick();
    check("irq_cleared", {15'b0, irq}, 16'h0000);
    wr(A_MASK, 16'h0002);
    tick();
    check("irq_tx_empty", {15'b0, irq}, 16'h0001);
    wr(A_MASK, 16'h0000);
    tick();
    check("irq_masked", {15'b0, irq}, 16'h0000);
`else
    wr(A_MASK, 16'h0003);
    rd(A_MASK, 16'h0000, "mask_rd_absent");
    rx_in(8'h10);
    tick();
    check("irq_absent", {15'b0, irq}, 16'h0000);
    irqack = 1'b1;
    tick();
    irqack = 1'b0;
    check("irq_absent_ack", {15'b0, irq}, 16'h0000);
    rd(A_RXD, 16'h0010, "irq_rx_data");
`endif

    // Halt strobe and unmapped offsets
    wr(11'd512, 16'h0001);
    check("halt_pulse", {15'b0, halt}, 16'h0001);
    tick();
    check("halt_one_cycle", {15'b0, halt}, 16'h0000);
    wr(11'd514, 16'h0001);
    check("halt_other_off", {15'b0, halt}, 16'h0000);
    rd(11'd12, 16'h0000, "unmapped_rd");
    rd(11'd512, 16'h0000, "halt_rd_zero");

    tick();
    tick();
    check("rd_q_drained", 16'(rd_q.size()), 16'h0000);
    check("tx_q_drained", 16'(tx_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
